// File: rtl/cache_level_1_sa.sv
// Set-associative L1 cache, write-back / write-allocate, per-set age-based LRU.
// A miss stalls the core, optionally writes back a dirty victim, fetches the block and waits for the fill.
module cache_level_1_sa #(
    parameter int BW_CORE_ADDR_BYTE     = 32,
    parameter int BW_USED_ADDR_BYTE     = 26,
    parameter int BW_DATA_WORD          = 32,
    parameter int CACHE_WORDS_PER_BLOCK = 16,
    parameter int CACHE_CAPACITY_BLOCKS = 128,
    parameter int CACHE_ASSOCIATIVITY   = 2,
    parameter int BW_CACHE_COMMAND      = 3,
    parameter int BW_CONFIG_REGS        = 32
) (
    input  logic                                            clock_i,
    input  logic                                            reset_i,
    input  logic                                            core_request_i,
    input  logic                                            core_wren_i,
    input  logic [BW_CORE_ADDR_BYTE-1:0]                    core_addr_i,
    input  logic [BW_DATA_WORD-1:0]                         core_data_i,
    output logic                                            core_valid_o,
    output logic [BW_DATA_WORD-1:0]                         core_data_o,
    output logic                                            stall_o,
    output logic                                            external_write_o,
    output logic [BW_CACHE_COMMAND-1:0]                     external_command_o,
    output logic [BW_USED_ADDR_BYTE-3:0]                    external_addr_o,
    output logic [BW_DATA_WORD*CACHE_WORDS_PER_BLOCK-1:0]   external_data_o,
    input  logic                                            external_full_i,
    input  logic                                            external_write_i,
    input  logic [BW_CACHE_COMMAND-1:0]                     external_command_i,
    input  logic [BW_USED_ADDR_BYTE-3:0]                    external_addr_i,
    input  logic [BW_DATA_WORD*CACHE_WORDS_PER_BLOCK-1:0]   external_data_i,
    output logic                                            external_full_o,
    output logic [BW_CONFIG_REGS-1:0]                       hit_count_o,
    output logic [BW_CONFIG_REGS-1:0]                       miss_count_o,
    output logic [BW_CONFIG_REGS-1:0]                       writeback_count_o
);
    localparam int BW_USED_ADDR_WORD = BW_USED_ADDR_BYTE - 2;
    localparam int BW_BUS = BW_DATA_WORD * CACHE_WORDS_PER_BLOCK;
    localparam int N_SETS = CACHE_CAPACITY_BLOCKS / CACHE_ASSOCIATIVITY;
    localparam int OFF_W  = $clog2(CACHE_WORDS_PER_BLOCK);
    localparam int SET_W  = $clog2(N_SETS);
    localparam int TAG_W  = BW_USED_ADDR_WORD - SET_W - OFF_W;
    localparam int WAY_W  = (CACHE_ASSOCIATIVITY > 1) ? $clog2(CACHE_ASSOCIATIVITY) : 1;

    localparam logic [BW_CACHE_COMMAND-1:0] CMD_FETCH = BW_CACHE_COMMAND'(1);
    localparam logic [BW_CACHE_COMMAND-1:0] CMD_WB    = BW_CACHE_COMMAND'(2);
    localparam logic [BW_CACHE_COMMAND-1:0] CMD_FILL  = BW_CACHE_COMMAND'(4);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, WAIT_FILL} state_t;
    state_t state;

    logic              valid_q [N_SETS][CACHE_ASSOCIATIVITY];
    logic              dirty_q [N_SETS][CACHE_ASSOCIATIVITY];
    logic [TAG_W-1:0]  tag_q   [N_SETS][CACHE_ASSOCIATIVITY];
    logic [BW_BUS-1:0] data_q  [N_SETS][CACHE_ASSOCIATIVITY];
    logic [WAY_W-1:0]  age_q   [N_SETS][CACHE_ASSOCIATIVITY];

    logic [BW_USED_ADDR_WORD-1:0] req_word;
    logic [OFF_W-1:0]             req_off;
    logic [SET_W-1:0]             req_set;
    logic [TAG_W-1:0]             req_tag;

    assign req_word = core_addr_i[BW_USED_ADDR_BYTE-1:2];
    assign req_off  = req_word[OFF_W-1:0];
    assign req_set  = req_word[OFF_W +: SET_W];
    assign req_tag  = req_word[BW_USED_ADDR_WORD-1 -: TAG_W];

    logic unused_addr;
    assign unused_addr = ^core_addr_i;

    // Pending miss context, held until the fill lands
    logic [OFF_W-1:0]        miss_off;
    logic [SET_W-1:0]        miss_set;
    logic [TAG_W-1:0]        miss_tag;
    logic [WAY_W-1:0]        miss_way;
    logic                    miss_wr;
    logic [BW_DATA_WORD-1:0] miss_wdata;
    logic [BW_USED_ADDR_WORD-1:0] miss_base;
    assign miss_base = {miss_tag, miss_set, {OFF_W{1'b0}}};

    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, victim_way;

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        inv_found  = 1'b0;
        victim_way = '0;
        for (int w = 0; w < CACHE_ASSOCIATIVITY; w++) begin
            if (!hit && valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[req_set][w]) begin
                inv_found  = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
        if (!inv_found)
            for (int w = 0; w < CACHE_ASSOCIATIVITY; w++)
                if (age_q[req_set][w] == WAY_W'(CACHE_ASSOCIATIVITY - 1))
                    victim_way = WAY_W'(w);
    end

    logic              fill_ok;
    logic [BW_BUS-1:0] fill_line;
    assign fill_ok = external_write_i && (external_command_i == CMD_FILL) &&
                     (external_addr_i == miss_base);

    always_comb begin
        fill_line = external_data_i;
        if (miss_wr)
            fill_line[int'(miss_off)*BW_DATA_WORD +: BW_DATA_WORD] = miss_wdata;
    end

    // One LRU touch per cycle: either an IDLE hit or an accepted fill
    logic             touch_en;
    logic [SET_W-1:0] touch_set;
    logic [WAY_W-1:0] touch_way;
    assign touch_en  = (state == IDLE && core_request_i && hit) || (state == WAIT_FILL && fill_ok);
    assign touch_set = (state == IDLE) ? req_set : miss_set;
    assign touch_way = (state == IDLE) ? hit_way : miss_way;

    assign external_write_o = (state == WRITEBACK || state == FETCH) && !external_full_i;

    function automatic logic [BW_CONFIG_REGS-1:0] sat_inc(input logic [BW_CONFIG_REGS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state              <= IDLE;
            for (int s = 0; s < N_SETS; s++)
                for (int w = 0; w < CACHE_ASSOCIATIVITY; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            hit_count_o        <= '0;
            miss_count_o       <= '0;
            writeback_count_o  <= '0;
            core_valid_o       <= 1'b0;
            core_data_o        <= '0;
            stall_o            <= 1'b0;
            external_command_o <= '0;
            external_addr_o    <= '0;
            external_data_o    <= '0;
            external_full_o    <= 1'b1;
            miss_off           <= '0;
            miss_set           <= '0;
            miss_tag           <= '0;
            miss_way           <= '0;
            miss_wr            <= 1'b0;
            miss_wdata         <= '0;
        end else begin
            core_valid_o <= 1'b0;
            if (touch_en) begin
                for (int i = 0; i < CACHE_ASSOCIATIVITY; i++)
                    if (age_q[touch_set][i] < age_q[touch_set][touch_way])
                        age_q[touch_set][i] <= age_q[touch_set][i] + 1'b1;
                age_q[touch_set][touch_way] <= '0;
            end
            case (state)
                IDLE: if (core_request_i) begin
                    if (hit) begin
                        core_valid_o <= 1'b1;
                        hit_count_o  <= sat_inc(hit_count_o);
                        if (core_wren_i) begin
                            data_q[req_set][hit_way][int'(req_off)*BW_DATA_WORD +: BW_DATA_WORD] <= core_data_i;
                            dirty_q[req_set][hit_way] <= 1'b1;
                            core_data_o <= core_data_i;
                        end else begin
                            core_data_o <= data_q[req_set][hit_way][int'(req_off)*BW_DATA_WORD +: BW_DATA_WORD];
                        end
                    end else begin
                        miss_off     <= req_off;
                        miss_set     <= req_set;
                        miss_tag     <= req_tag;
                        miss_way     <= victim_way;
                        miss_wr      <= core_wren_i;
                        miss_wdata   <= core_data_i;
                        miss_count_o <= sat_inc(miss_count_o);
                        stall_o      <= 1'b1;
                        if (valid_q[req_set][victim_way] && dirty_q[req_set][victim_way]) begin
                            state              <= WRITEBACK;
                            external_command_o <= CMD_WB;
                            external_addr_o    <= {tag_q[req_set][victim_way], req_set, {OFF_W{1'b0}}};
                            external_data_o    <= data_q[req_set][victim_way];
                        end else begin
                            state              <= FETCH;
                            external_command_o <= CMD_FETCH;
                            external_addr_o    <= {req_tag, req_set, {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: if (!external_full_i) begin
                    valid_q[miss_set][miss_way] <= 1'b0;
                    dirty_q[miss_set][miss_way] <= 1'b0;
                    writeback_count_o  <= sat_inc(writeback_count_o);
                    state              <= FETCH;
                    external_command_o <= CMD_FETCH;
                    external_addr_o    <= miss_base;
                    external_data_o    <= '0;
                end
                FETCH: if (!external_full_i) begin
                    state              <= WAIT_FILL;
                    external_command_o <= '0;
                    external_addr_o    <= '0;
                    external_full_o    <= 1'b0;
                end
                WAIT_FILL: if (fill_ok) begin
                    valid_q[miss_set][miss_way] <= 1'b1;
                    dirty_q[miss_set][miss_way] <= miss_wr;
                    tag_q[miss_set][miss_way]   <= miss_tag;
                    data_q[miss_set][miss_way]  <= fill_line;
                    state           <= IDLE;
                    external_full_o <= 1'b1;
                    stall_o         <= 1'b0;
                    core_valid_o    <= 1'b1;
                    core_data_o     <= fill_line[int'(miss_off)*BW_DATA_WORD +: BW_DATA_WORD];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cache_level_1_sa.md
CACHE_LEVEL_1_SA -- requirements
Module: cache_level_1_sa

Interface
REQ-001 SHALL have parameter BW_CORE_ADDR_BYTE, default 32: width of the core byte address.
REQ-002 SHALL have parameter BW_USED_ADDR_BYTE, default 26: byte-address bits used; BW_USED_ADDR_WORD = BW_USED_ADDR_BYTE-2.
REQ-003 SHALL have parameter BW_DATA_WORD, default 32: data word width.
REQ-004 SHALL have parameter CACHE_WORDS_PER_BLOCK, default 16: words per line, power of two; BW_DATA_EXTERNAL_BUS = BW_DATA_WORD*CACHE_WORDS_PER_BLOCK.
REQ-005 SHALL have parameter CACHE_CAPACITY_BLOCKS, default 128: total lines, power of two.
REQ-006 SHALL have parameter CACHE_ASSOCIATIVITY, default 2: ways per set, one of 1/2/4/8, dividing CACHE_CAPACITY_BLOCKS; N_SETS = CAPACITY/ASSOCIATIVITY.
REQ-007 SHALL have parameter BW_CACHE_COMMAND, default 3: external command width.
REQ-008 SHALL have parameter BW_CONFIG_REGS, default 32: width of the statistics counters.
REQ-009 SHALL have ports: clock_i in 1 (sole clock); reset_i in 1 (synchronous, active-high).
REQ-010 SHALL have ports: core_request_i in 1; core_wren_i in 1; core_addr_i in BW_CORE_ADDR_BYTE; core_data_i in BW_DATA_WORD; core_valid_o out 1; core_data_o out BW_DATA_WORD; stall_o out 1.
REQ-011 SHALL have ports: external_write_o out 1; external_command_o out BW_CACHE_COMMAND; external_addr_o out BW_USED_ADDR_WORD; external_data_o out BW_DATA_EXTERNAL_BUS; external_full_i in 1.
REQ-012 SHALL have ports: external_write_i in 1; external_command_i in BW_CACHE_COMMAND; external_addr_i in BW_USED_ADDR_WORD; external_data_i in BW_DATA_EXTERNAL_BUS; external_full_o out 1.
REQ-013 SHALL have ports: hit_count_o, miss_count_o, writeback_count_o out BW_CONFIG_REGS each.

Function
REQ-014 SHALL decompose word address core_addr_i[BW_USED_ADDR_BYTE-1:2] as {tag, set index, word offset}, offset LSBs.
REQ-015 SHALL store per line: valid, dirty, tag, data; per set: LRU age per way (width clog2(ASSOCIATIVITY)).
REQ-016 SHALL implement FSM states IDLE, WRITEBACK, FETCH, WAIT_FILL.
REQ-017 SHALL in IDLE sample core_request_i each edge; requests while stall_o high ignored (core holds them).
REQ-018 SHALL on hit: read -> core_valid_o pulse one cycle after sampling edge, core_data_o = addressed word; write -> word updated, dirty set, core_valid_o pulse, core_data_o = core_data_i; state stays IDLE; hit_count +1.
REQ-019 SHALL on miss: stall_o high from next cycle until the core_valid_o cycle; miss_count +1; victim = lowest-index invalid way, else way with age ASSOCIATIVITY-1; next state WRITEBACK if victim valid and dirty, else FETCH.
REQ-020 SHALL in WRITEBACK drive external_write_o = !external_full_i, command 3'b010, addr = victim block base word address (offset 0), data = victim line; on transfer edge clear victim valid, writeback_count +1, go FETCH.
REQ-021 SHALL in FETCH drive external_write_o = !external_full_i, command 3'b001, addr = missed block base; on transfer go WAIT_FILL.
REQ-022 SHALL drive external_full_o low only in WAIT_FILL; fills accepted only when external_write_i, command 3'b100 and addr equal to fetched block base; other inputs dropped.
REQ-023 SHALL on accepted fill write line into victim way (valid=1, tag), merge core_data_i into offset and set dirty if write miss else dirty=0, go IDLE, pulse core_valid_o next cycle with requested/written word.
REQ-024 SHALL on every access to way w (hit or fill): ages below age[w] +1, age[w] = 0.
REQ-025 SHALL saturate statistics counters at all-ones.
REQ-026 SHALL hold external_write_o low and external_command_o/addr/data at zero in IDLE and WAIT_FILL.

Reset
REQ-027 SHALL on reset_i: state IDLE; all valid/dirty cleared; age[w] = w per set; counters 0; core_valid_o, core_data_o, stall_o, external_write_o 0; external_full_o 1.
REQ-028 SHALL on reset mid-miss abandon transaction without writeback; late fills ignored.

Verification (ASSOC=2, 4 words/block, 8 blocks, BW_USED_ADDR_BYTE=16)
REQ-029 Reset, read 0x0040 -> one cmd 3'b001 addr 0x0010; fill {w3..w0}; core_valid_o next cycle with w0; miss_count=1.
REQ-030 Read 0x0044 -> core_valid_o at T+1 with w1, no external traffic, hit_count=1.
REQ-031 Write 0x0048 = 0xDEADBEEF, read 0x0048 -> returns 0xDEADBEEF, hits only.
REQ-032 Then read 0x0000 (miss, fill), read 0x0080 -> writeback cmd 3'b010 addr 0x0010 data word2=0xDEADBEEF, then cmd 3'b001 addr 0x0020; writeback_count=1.
REQ-033 external_full_i high 5 cycles in FETCH -> external_write_o low, stall_o high throughout; transfer on first low cycle.
REQ-034 Reset in WAIT_FILL, then matching fill -> ignored (external_full_o=1); read 0x0040 misses again.
